// File: rtl/seq_tx.sv
// Serial pattern transmitter: loads a parallel pattern and shifts it out MSB-first,
// optionally repeating it with a programmable idle gap between copies.
module seq_tx #(
    parameter int PAT_W = 4,
    parameter int RPT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [RPT_W-1:0] rpt,      // extra copies; total copies = rpt+1
    input  logic [GAP_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    logic [PAT_W-1:0]   sh_pat;
    logic [GAP_W-1:0]   sh_gap;
    logic [RPT_W-1:0]   copy_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   idx;

    // state always names what the registered outputs are showing this cycle;
    // idx is the pattern bit currently on out
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_pat   <= '0;
            sh_gap   <= '0;
            copy_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            out      <= 1'b0;
            valid    <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: a non-blocking default here is overridden by any later <= in the same block.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_pat   <= pattern;
                        sh_gap   <= gap;
                        copy_cnt <= rpt;
                        idx      <= IDX_TOP;
                        out      <= pattern[PAT_W-1];
                        valid    <= 1'b1;
                        last     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (idx != '0) begin
                        idx  <= idx - IDX_W'(1);
                        out  <= sh_pat[idx - IDX_W'(1)];
                        last <= (idx == IDX_W'(1));
                    end else if (copy_cnt == '0) begin
                        state <= IDLE;
                        out   <= 1'b0;
                        valid <= 1'b0;
                        last  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        copy_cnt <= copy_cnt - RPT_W'(1);
                        last     <= 1'b0;
                        if (sh_gap == '0) begin
                            idx <= IDX_TOP;
                            out <= sh_pat[PAT_W-1];
                        end else begin
                            // gap_cnt holds the idle cycles still owed after the current one
                            state   <= GAP;
                            gap_cnt <= sh_gap - GAP_W'(1);
                            out     <= 1'b0;
                            valid   <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= SEND;
                        idx   <= IDX_TOP;
                        out   <= sh_pat[PAT_W-1];
                        valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: a frame-level model expands (pattern, copies, gap)
// into the expected per-cycle {out,valid,last,busy,done} stream.
module tb_seq_tx;
    typedef logic [4:0] vec_t;  // {out, valid, last, busy, done}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start6 = 1'b0;
    logic [3:0] pattern = '0, rpt = '0, gap = '0;
    logic [5:0] pattern6 = '0;
    logic [3:0] rpt6 = '0, gap6 = '0;
    logic       out, valid, last, busy, done;
    logic       out6, valid6, last6, busy6, done6;

    int   vectors = 0;
    int   miscompares = 0;
    vec_t exp_q[$];
    vec_t obs;

    seq_tx #(.PAT_W(4), .RPT_W(4), .GAP_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .rpt(rpt), .gap(gap),
        .out(out), .valid(valid), .last(last), .busy(busy), .done(done)
    );

    seq_tx #(.PAT_W(6), .RPT_W(4), .GAP_W(4)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .pattern(pattern6), .rpt(rpt6), .gap(gap6),
        .out(out6), .valid(valid6), .last(last6), .busy(busy6), .done(done6)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    function automatic vec_t obs4();
        return {out, valid, last, busy, done};
    endfunction

    function automatic vec_t obs6();
        return {out6, valid6, last6, busy6, done6};
    endfunction

    // Frame model: each copy is w bits MSB-first, gaps only between copies, then one done cycle.
    function automatic void build(input logic [5:0] p, input int w, input int r, input int g);
        exp_q.delete();
        for (int c = 0; c <= r; c++) begin
            for (int i = w - 1; i >= 0; i--)
                exp_q.push_back({p[i], 1'b1, (i == 0), 1'b1, 1'b0});
            if (c < r)
                for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
    endfunction

    // Returns at the falling edge of the first cycle after start was sampled.
    task automatic launch(input bit wide, input logic [5:0] p, input int r, input int g);
        @(negedge clk);
        // NOTE: inputs change on the falling edge so the DUT samples settled values.
        if (wide) begin
            start6 = 1'b1; pattern6 = p; rpt6 = 4'(r); gap6 = 4'(g);
        end else begin
            start = 1'b1; pattern = p[3:0]; rpt = 4'(r); gap = 4'(g);
        end
        @(negedge clk);
        start  = 1'b0;
        start6 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs4() !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset4: got %b expected %b", obs4(), 5'b00000);
        end
        vectors++;
        if (obs6() !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset6: got %b expected %b", obs6(), 5'b00000);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        build(6'b001011, 4, 0, 0);
        launch(1'b0, 6'b001011, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL single cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sr = '0;
        int hits = 0;
        build(6'b001011, 4, 2, 0);
        launch(1'b0, 6'b001011, 2, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            obs = obs4();
            if (obs[3]) begin
                sr = {sr[2:0], obs[4]};
                if (sr == 4'b1011) hits++;
            end
            vectors++;
            if (obs !== exp_q[k]) begin
                miscompares++;
                $display("FAIL b2b cycle %0d: got %b expected %b", k + 1, obs, exp_q[k]);
            end
        end
        vectors++;
        if (hits !== 3) begin
            miscompares++;
            $display("FAIL b2b detector hits: got %0d expected 3", hits);
        end
    endtask

    task automatic test_gapped();
        build(6'b001011, 4, 1, 2);
        launch(1'b0, 6'b001011, 1, 2);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL gapped cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        build(6'b001011, 4, 0, 0);
        launch(1'b0, 6'b001011, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL ignore cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
            if (k == 1) begin
                start = 1'b1; pattern = 4'b0110; rpt = 4'd3; gap = 4'd5;
            end
            if (k == exp_q.size() - 1) start = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (obs4() !== 5'b00000) begin
                miscompares++;
                $display("FAIL ignore idle %0d: got %b expected %b", k, obs4(), 5'b00000);
            end
        end
    endtask

    task automatic test_done_restart();
        build(6'b001011, 4, 0, 0);
        launch(1'b0, 6'b001011, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL restart A cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
        start = 1'b1; pattern = 4'b0110; rpt = 4'd1; gap = 4'd1;
        @(negedge clk);
        start = 1'b0;
        build(6'b000110, 4, 1, 1);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL restart B cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        build(6'b001011, 4, 1, 0);
        launch(1'b0, 6'b001011, 1, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL midrst cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== 5'b00000) begin
                miscompares++;
                $display("FAIL midrst quiet %0d: got %b expected %b", k, obs4(), 5'b00000);
            end
        end
        build(6'b001011, 4, 0, 0);
        launch(1'b0, 6'b001011, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs4() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL midrst fresh cycle %0d: got %b expected %b", k + 1, obs4(), exp_q[k]);
            end
        end
    endtask

    task automatic test_width6();
        build(6'b100001, 6, 0, 0);
        launch(1'b1, 6'b100001, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (obs6() !== exp_q[k]) begin
                miscompares++;
                $display("FAIL width6 cycle %0d: got %b expected %b", k + 1, obs6(), exp_q[k]);
            end
        end
    endtask

    // Random frames with junk start pulses and input changes injected while busy.
    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            logic [3:0] p = 4'($urandom);
            int r = int'($urandom_range(0, 3));
            int g = int'($urandom_range(0, 3));
            int idle = int'($urandom_range(0, 2));
            build({2'b00, p}, 4, r, g);
            launch(1'b0, {2'b00, p}, r, g);
            for (int k = 0; k < exp_q.size(); k++) begin
                if (k > 0) @(negedge clk);
                vectors++;
                if (obs4() !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL random frame %0d cycle %0d: got %b expected %b",
                             f, k + 1, obs4(), exp_q[k]);
                end
                if (k < exp_q.size() - 1) begin
                    start = 1'($urandom); pattern = 4'($urandom);
                    rpt = 4'($urandom); gap = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
            end
            for (int k = 0; k < idle; k++) begin
                @(negedge clk);
                vectors++;
                if (obs4() !== 5'b00000) begin
                    miscompares++;
                    $display("FAIL random frame %0d idle %0d: got %b expected %b",
                             f, k, obs4(), 5'b00000);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gapped();
        test_busy_ignore();
        test_done_restart();
        test_reset_mid_frame();
        test_width6();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
